// File: rtl/pwm_motor_ctrl.sv
// Two-channel PWM motor controller with an SPI-fed register file,
// direction-change dead period and a command watchdog.
module pwm_motor_ctrl #(
   parameter int unsigned PWM_PERIOD = 2500,
   parameter int unsigned WD_TIMEOUT = 5_000_000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        spi_cs,
   input  logic [39:0] frame,
   output logic        pwm_l,
   output logic        pwm_r,
   output logic        dir_l,
   output logic        dir_r,
   output logic        running,
   output logic        wd_trip,
   output logic [15:0] cmd_count
);

   localparam int unsigned CW = $clog2(PWM_PERIOD + 1);
   localparam int unsigned WW = (WD_TIMEOUT > 2) ? $clog2(WD_TIMEOUT) : 1;

   localparam logic [7:0] ADDR_DUTY_L = 8'h80;
   localparam logic [7:0] ADDR_DUTY_R = 8'h81;
   localparam logic [7:0] ADDR_CTRL   = 8'h82;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_TRIP = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic            cs_s1_q, cs_s2_q, cs_e_q;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [WW-1:0]   wd_q, wd_d;
   logic [15:0]     duty_l_q, duty_l_d, duty_r_q, duty_r_d;
   logic [CW-1:0]   mag_l_q, mag_l_d, mag_r_q, mag_r_d;
   logic            dir_l_q, dir_l_d, dir_r_q, dir_r_d;
   logic            dead_l_q, dead_l_d, dead_r_q, dead_r_d;
   logic            pwm_l_q, pwm_l_d, pwm_r_q, pwm_r_d;
   logic            run_q, run_d, trip_q, trip_d;
   logic [15:0]     cmd_q, cmd_d;

   logic            eof_c, wr_l_c, wr_r_c, wr_ctrl_c, accept_c, wrap_c;
   logic [7:0]      addr_c;
   logic [15:0]     data_c;
   logic            unused_frame;

   // Signed duty value to magnitude, saturated to a full period
   function automatic logic [CW-1:0] sat_mag(input logic [15:0] v);
      logic [16:0] m;
      m = v[15] ? (17'h1_0000 - {1'b0, v}) : {1'b0, v};
      if (m >= 17'(PWM_PERIOD)) return CW'(PWM_PERIOD);
      return CW'(m);
   endfunction

   // spi_cs synchronizer plus edge register for end-of-frame detection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cs_s1_q <= 1'b0;
         cs_s2_q <= 1'b0;
         cs_e_q  <= 1'b0;
      end else begin
         cs_s1_q <= spi_cs;
         cs_s2_q <= cs_s1_q;
         cs_e_q  <= cs_s2_q;
      end
   end

   // Frame decode; frame is stable while spi_cs is high
   assign eof_c     = cs_s2_q & ~cs_e_q;
   assign addr_c    = frame[39:32];
   assign data_c    = frame[15:0];
   assign wr_l_c    = eof_c && (addr_c == ADDR_DUTY_L);
   assign wr_r_c    = eof_c && (addr_c == ADDR_DUTY_R);
   assign wr_ctrl_c = eof_c && (addr_c == ADDR_CTRL);
   assign accept_c  = wr_l_c | wr_r_c | wr_ctrl_c;
   assign wrap_c    = (cnt_q == CW'(PWM_PERIOD - 1));
   assign unused_frame = ^frame[31:16];

   // Next-state, register file, watchdog and PWM datapath
   always_comb begin
      state_d  = state_q;
      cnt_d    = wrap_c ? '0 : cnt_q + CW'(1);
      wd_d     = wd_q;
      duty_l_d = duty_l_q;
      duty_r_d = duty_r_q;
      mag_l_d  = mag_l_q;
      mag_r_d  = mag_r_q;
      dir_l_d  = dir_l_q;
      dir_r_d  = dir_r_q;
      dead_l_d = dead_l_q;
      dead_r_d = dead_r_q;
      trip_d   = trip_q;
      cmd_d    = cmd_q;

      if (accept_c) cmd_d = cmd_q + 16'd1;

      unique case (state_q)
         ST_IDLE: if (wr_ctrl_c && data_c[0]) state_d = ST_RUN;
         ST_RUN: begin
            if (wr_ctrl_c && !data_c[0]) state_d = ST_IDLE;
            else if (!accept_c && (wd_q == WW'(WD_TIMEOUT - 1))) state_d = ST_TRIP;
         end
         ST_TRIP: if (wr_ctrl_c && data_c[1]) state_d = data_c[0] ? ST_RUN : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      wd_d = (accept_c || (state_q != ST_RUN)) ? '0 : wd_q + WW'(1);

      if (wr_ctrl_c && data_c[1]) trip_d = 1'b0;

      if (state_q != ST_TRIP) begin
         if (wr_l_c) duty_l_d = data_c;
         if (wr_r_c) duty_r_d = data_c;
      end

      // Period-boundary reload; a direction change costs one dead period
      if ((state_q == ST_RUN) && wrap_c) begin
         if ((dir_l_q != duty_l_q[15]) && !dead_l_q) begin
            mag_l_d  = '0;
            dead_l_d = 1'b1;
         end else begin
            dir_l_d  = duty_l_q[15];
            mag_l_d  = sat_mag(duty_l_q);
            dead_l_d = 1'b0;
         end
         if ((dir_r_q != duty_r_q[15]) && !dead_r_q) begin
            mag_r_d  = '0;
            dead_r_d = 1'b1;
         end else begin
            dir_r_d  = duty_r_q[15];
            mag_r_d  = sat_mag(duty_r_q);
            dead_r_d = 1'b0;
         end
      end

      if ((state_q == ST_RUN) && (state_d == ST_TRIP)) begin
         trip_d   = 1'b1;
         duty_l_d = '0;
         duty_r_d = '0;
         mag_l_d  = '0;
         mag_r_d  = '0;
         dead_l_d = 1'b0;
         dead_r_d = 1'b0;
      end

      run_d   = (state_d == ST_RUN);
      pwm_l_d = run_d && (cnt_d < mag_l_d);
      pwm_r_d = run_d && (cnt_d < mag_r_d);
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         wd_q     <= '0;
         duty_l_q <= '0;
         duty_r_q <= '0;
         mag_l_q  <= '0;
         mag_r_q  <= '0;
         dir_l_q  <= 1'b0;
         dir_r_q  <= 1'b0;
         dead_l_q <= 1'b0;
         dead_r_q <= 1'b0;
         pwm_l_q  <= 1'b0;
         pwm_r_q  <= 1'b0;
         run_q    <= 1'b0;
         trip_q   <= 1'b0;
         cmd_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wd_q     <= wd_d;
         duty_l_q <= duty_l_d;
         duty_r_q <= duty_r_d;
         mag_l_q  <= mag_l_d;
         mag_r_q  <= mag_r_d;
         dir_l_q  <= dir_l_d;
         dir_r_q  <= dir_r_d;
         dead_l_q <= dead_l_d;
         dead_r_q <= dead_r_d;
         pwm_l_q  <= pwm_l_d;
         pwm_r_q  <= pwm_r_d;
         run_q    <= run_d;
         trip_q   <= trip_d;
         cmd_q    <= cmd_d;
      end
   end

   assign pwm_l     = pwm_l_q;
   assign pwm_r     = pwm_r_q;
   assign dir_l     = dir_l_q;
   assign dir_r     = dir_r_q;
   assign running   = run_q;
   assign wd_trip   = trip_q;
   assign cmd_count = cmd_q;

endmodule

// File: tb/tb_pwm_motor_ctrl.sv
// Scoreboard bench for pwm_motor_ctrl: stimulus queues expected output
// values tagged with the cycle they must appear; a negedge monitor checks them.
module tb_pwm_motor_ctrl;

   localparam int F_PWM_L = 0;
   localparam int F_PWM_R = 1;
   localparam int F_DIR_L = 2;
   localparam int F_DIR_R = 3;
   localparam int F_RUN   = 4;
   localparam int F_TRIP  = 5;
   localparam int F_CNT   = 6;

   typedef struct {
      int at;
      int fld;
      int val;
   } exp_t;

   logic        clk;
   logic        reset_n;
   logic        spi_cs;
   logic [39:0] frame;
   logic        pwm_l, pwm_r, dir_l, dir_r, running, wd_trip;
   logic [15:0] cmd_count;

   int   cyc;
   int   n_checks;
   int   n_err;
   exp_t sb[$];

   pwm_motor_ctrl #(.PWM_PERIOD(10), .WD_TIMEOUT(300)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .spi_cs    (spi_cs),
      .frame     (frame),
      .pwm_l     (pwm_l),
      .pwm_r     (pwm_r),
      .dir_l     (dir_l),
      .dir_r     (dir_r),
      .running   (running),
      .wd_trip   (wd_trip),
      .cmd_count (cmd_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle index: after rising edge n since reset release, cyc == n
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   function automatic string fname(input int f);
      case (f)
         F_PWM_L: return "pwm_l";
         F_PWM_R: return "pwm_r";
         F_DIR_L: return "dir_l";
         F_DIR_R: return "dir_r";
         F_RUN:   return "running";
         F_TRIP:  return "wd_trip";
         default: return "cmd_count";
      endcase
   endfunction

   function automatic int actual(input int f);
      case (f)
         F_PWM_L: return int'(pwm_l);
         F_PWM_R: return int'(pwm_r);
         F_DIR_L: return int'(dir_l);
         F_DIR_R: return int'(dir_r);
         F_RUN:   return int'(running);
         F_TRIP:  return int'(wd_trip);
         default: return int'(cmd_count);
      endcase
   endfunction

   function automatic void check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endfunction

   // Insert keeping the queue ordered by due cycle
   function automatic void push(input int at, input int fld, input int val);
      exp_t e;
      int   i;
      e.at = at; e.fld = fld; e.val = val;
      i = 0;
      while (i < sb.size() && sb[i].at <= at) i++;
      sb.insert(i, e);
   endfunction

   // Monitor: pop and compare every expectation due this cycle
   always @(negedge clk) begin : mon
      exp_t e;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
         e = sb.pop_front();
         if (e.at < cyc) begin
            n_checks++;
            n_err++;
            $display("FAIL missed_%s@%0d actual=unsampled required=%0d", fname(e.fld), e.at, e.val);
         end else begin
            check($sformatf("%s@%0d", fname(e.fld), e.at), actual(e.fld), e.val);
         end
      end
   end

   task automatic go_to(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Raise spi_cs just after edge e: registers update on edge e+3
   task automatic spi_write(input logic [7:0] a, input logic [31:0] d);
      int e;
      e      = cyc;
      frame  = {a, d};
      spi_cs = 1'b1;
      go_to(e + 3);
      spi_cs = 1'b0;
      go_to(e + 6);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      n_checks = 0;
      n_err    = 0;
      reset_n  = 1'b0;
      spi_cs   = 1'b0;
      frame    = '0;

      push(0, F_PWM_L, 0); push(0, F_RUN, 0); push(0, F_CNT, 0); push(0, F_TRIP, 0);
      #32 reset_n = 1'b1;

      // Left duty +5 in IDLE; update lands on edge 5, not 4
      push(1, F_DIR_L, 0); push(4, F_CNT, 0); push(5, F_CNT, 1);
      go_to(2);
      spi_write(8'h80, 32'h0000_0005);

      // Enable: RUN at edge 11, magnitude applied from wrap at edge 20
      push(10, F_RUN, 0); push(11, F_RUN, 1); push(11, F_CNT, 2); push(19, F_PWM_L, 0);
      for (int c = 20; c < 30; c++) push(c, F_PWM_L, (c < 25) ? 1 : 0);
      push(25, F_DIR_L, 0);
      spi_write(8'h82, 32'h0000_0001);

      // Reverse left: old pulse, dead period 40..49, then dir=1 pulses
      go_to(30);
      for (int c = 30; c < 40; c++) push(c, F_PWM_L, (c < 35) ? 1 : 0);
      push(36, F_CNT, 3); push(39, F_DIR_L, 0); push(45, F_DIR_L, 0);
      for (int c = 40; c < 50; c += 3) push(c, F_PWM_L, 0);
      push(50, F_DIR_L, 1); push(50, F_PWM_L, 1); push(54, F_PWM_L, 1); push(55, F_PWM_L, 0);
      spi_write(8'h80, 32'h0000_FFFB);

      // Right +0x7FFF saturates to full period
      go_to(60);
      push(66, F_CNT, 4); push(69, F_PWM_R, 0); push(70, F_PWM_R, 1); push(70, F_DIR_R, 0);
      push(75, F_PWM_R, 1); push(79, F_PWM_R, 1);
      spi_write(8'h81, 32'h0000_7FFF);

      // Right -32768: dead period 80..89, then dir=1 constantly high
      go_to(72);
      push(75, F_CNT, 5); push(80, F_PWM_R, 0); push(85, F_PWM_R, 0); push(89, F_PWM_R, 0);
      push(89, F_DIR_R, 0); push(90, F_DIR_R, 1); push(90, F_PWM_R, 1); push(99, F_PWM_R, 1);
      spi_write(8'h81, 32'h0000_8000);

      // Unmapped address: no count, no watchdog kick
      push(84, F_CNT, 5); push(92, F_PWM_L, 1); push(96, F_PWM_L, 0); push(95, F_CNT, 5);
      spi_write(8'h05, 32'h0000_1234);

      // Watchdog: last accepted write at edge 75, trip on edge 375
      push(370, F_PWM_L, 1); push(370, F_PWM_R, 1);
      push(374, F_RUN, 1); push(374, F_TRIP, 0); push(374, F_PWM_L, 1);
      push(375, F_RUN, 0); push(375, F_TRIP, 1); push(375, F_PWM_L, 0); push(375, F_PWM_R, 0);
      push(376, F_DIR_L, 1); push(376, F_DIR_R, 1);
      go_to(380);

      // Enable alone is ignored in TRIP
      push(384, F_RUN, 0); push(386, F_TRIP, 1);
      spi_write(8'h82, 32'h0000_0001);

      // Clear+enable: back to RUN with zeroed duties
      push(388, F_TRIP, 1); push(389, F_TRIP, 0); push(389, F_RUN, 1);
      push(392, F_PWM_L, 0); push(392, F_PWM_R, 0);
      spi_write(8'h82, 32'h0000_0003);

      // New left duty after trip; active from wrap at edge 400
      push(400, F_PWM_L, 1); push(401, F_PWM_L, 1); push(401, F_DIR_L, 0);
      push(401, F_RUN, 1); push(401, F_PWM_R, 0);
      spi_write(8'h80, 32'h0000_0005);

      // Asynchronous reset mid-pulse
      go_to(402);
      #1 reset_n = 1'b0;
      #1;
      check("async_rst_pwm_l", int'(pwm_l), 0);
      check("async_rst_running", int'(running), 0);
      check("async_rst_cmd_count", int'(cmd_count), 0);
      #20 reset_n = 1'b1;

      // After reset the PWM counter restarts from 0
      push(1, F_CNT, 0); push(1, F_RUN, 0); push(1, F_DIR_L, 0);
      push(4, F_CNT, 0); push(5, F_CNT, 1);
      go_to(2);
      spi_write(8'h80, 32'h0000_0003);
      push(11, F_RUN, 1); push(11, F_CNT, 2);
      push(20, F_PWM_L, 1); push(22, F_PWM_L, 1); push(23, F_PWM_L, 0);
      push(29, F_PWM_L, 0); push(30, F_PWM_L, 1);
      spi_write(8'h82, 32'h0000_0001);
      go_to(32);

      check("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
